// File: rtl/window_mapper.sv
// Programmable address-window mapper: shadow/active window register sets with
// atomic commit, and a two-stage lookup pipeline producing translated ROM addresses.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no commit pending; shadow writes accepted
// ST_BUSY | commit pending until the lookup pipeline drains; writes dropped
module window_mapper #(
    parameter int NWIN = 4,
    parameter int AW   = 24
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_win,
    input  logic [1:0]    cfg_field,
    input  logic [AW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    input  logic [AW-1:0] SNES_ADDR,
    input  logic          addr_valid,
    output logic [AW-1:0] ROM_ADDR,
    output logic          ROM_HIT,
    output logic          IS_WRITABLE,
    output logic          IS_SAVERAM,
    output logic [3:0]    win_idx,
    output logic          out_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FLD_BASE  = 2'd0;
    localparam logic [1:0] FLD_MASK  = 2'd1;
    localparam logic [1:0] FLD_OFF   = 2'd2;
    localparam logic [1:0] FLD_FLAGS = 2'd3;

    state_t r_state;
    state_t w_state_nx;

    logic [AW-1:0] r_sh_base  [NWIN];
    logic [AW-1:0] r_sh_mask  [NWIN];
    logic [AW-1:0] r_sh_off   [NWIN];
    logic [2:0]    r_sh_flags [NWIN];

    logic [AW-1:0] w_sh_base_nx  [NWIN];
    logic [AW-1:0] w_sh_mask_nx  [NWIN];
    logic [AW-1:0] w_sh_off_nx   [NWIN];
    logic [2:0]    w_sh_flags_nx [NWIN];

    logic [AW-1:0] r_act_base  [NWIN];
    logic [AW-1:0] r_act_mask  [NWIN];
    logic [AW-1:0] r_act_off   [NWIN];
    logic [2:0]    r_act_flags [NWIN];

    logic            w_wr_en;
    logic            w_pipe_idle;
    logic            w_apply;

    logic [NWIN-1:0] w_match;
    logic            r_s1_valid;
    logic [AW-1:0]   r_s1_addr;
    logic [NWIN-1:0] r_s1_match;

    logic            w_hit;
    logic [3:0]      w_idx;
    logic [AW-1:0]   w_rom;
    logic            w_wr;
    logic            w_sr;

    logic            r_out_valid;
    logic [AW-1:0]   r_rom_addr;
    logic            r_rom_hit;
    logic            r_is_wr;
    logic            r_is_sr;
    logic [3:0]      r_win_idx;

    // The active set may only change when no lookup is in flight or arriving.
    assign w_pipe_idle = !addr_valid && !r_s1_valid && !r_out_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (cfg_commit && !w_pipe_idle) w_state_nx = ST_BUSY;
            ST_BUSY: if (w_pipe_idle)                w_state_nx = ST_IDLE;
            default:                                 w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_busy = (r_state == ST_BUSY);
        w_wr_en  = cfg_we && (r_state == ST_IDLE);
        w_apply  = ((r_state == ST_BUSY) || cfg_commit) && w_pipe_idle;
    end

    // Out-of-range window indices match no loop iteration and are dropped.
    always_comb begin
        w_sh_base_nx  = r_sh_base;
        w_sh_mask_nx  = r_sh_mask;
        w_sh_off_nx   = r_sh_off;
        w_sh_flags_nx = r_sh_flags;
        for (int i = 0; i < NWIN; i++) begin
            if (w_wr_en && (cfg_win == 4'(i))) begin
                case (cfg_field)
                    FLD_BASE:  w_sh_base_nx[i]  = cfg_data;
                    FLD_MASK:  w_sh_mask_nx[i]  = cfg_data;
                    FLD_OFF:   w_sh_off_nx[i]   = cfg_data;
                    FLD_FLAGS: w_sh_flags_nx[i] = cfg_data[2:0];
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NWIN; i++) begin
                r_sh_base[i]   <= '0;
                r_sh_mask[i]   <= '0;
                r_sh_off[i]    <= '0;
                r_sh_flags[i]  <= '0;
                r_act_base[i]  <= '0;
                r_act_mask[i]  <= '0;
                r_act_off[i]   <= '0;
                r_act_flags[i] <= '0;
            end
        end else begin
            r_sh_base  <= w_sh_base_nx;
            r_sh_mask  <= w_sh_mask_nx;
            r_sh_off   <= w_sh_off_nx;
            r_sh_flags <= w_sh_flags_nx;
            // Copy the post-write shadow so a same-cycle write joins the commit.
            if (w_apply) begin
                r_act_base  <= w_sh_base_nx;
                r_act_mask  <= w_sh_mask_nx;
                r_act_off   <= w_sh_off_nx;
                r_act_flags <= w_sh_flags_nx;
            end
        end
    end

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NWIN; i++) begin
            w_match[i] = r_act_flags[i][0] &&
                         ((SNES_ADDR & r_act_mask[i]) == (r_act_base[i] & r_act_mask[i]));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_match <= '0;
        end else begin
            r_s1_valid <= addr_valid;
            if (addr_valid) begin
                r_s1_addr  <= SNES_ADDR;
                r_s1_match <= w_match;
            end
        end
    end

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_rom = '0;
        w_wr  = 1'b0;
        w_sr  = 1'b0;
        for (int i = NWIN - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_hit = 1'b1;
                w_idx = 4'(i);
                w_rom = (r_s1_addr & ~r_act_mask[i]) + r_act_off[i];
                w_wr  = r_act_flags[i][1];
                w_sr  = r_act_flags[i][2];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_hit   <= 1'b0;
            r_is_wr     <= 1'b0;
            r_is_sr     <= 1'b0;
            r_win_idx   <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rom_addr <= w_rom;
                r_rom_hit  <= w_hit;
                r_is_wr    <= w_wr;
                r_is_sr    <= w_sr;
                r_win_idx  <= w_idx;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign ROM_ADDR    = r_rom_addr;
    assign ROM_HIT     = r_rom_hit;
    assign IS_WRITABLE = r_is_wr;
    assign IS_SAVERAM  = r_is_sr;
    assign win_idx     = r_win_idx;

endmodule
